// File: rtl/sparc_ram_loader_if.sv
// Bundles the byte-stream handshake and the RAM access bus of the loader.
// The master modport is the loader's view. The slave modport is the
// environment that supplies the stream and models the RAM.
interface sparc_ram_loader_if #(
  parameter int ADDR_W     = 9,
  parameter int WORD_BYTES = 4
);
  logic                    InValid;
  logic                    InReady;
  logic [7:0]              InData;
  logic                    InLast;
  logic                    MemEnable;
  logic                    MemRW;
  logic [ADDR_W-1:0]       MemAddr;
  logic [8*WORD_BYTES-1:0] MemData;
  logic [1:0]              MemMode;
  logic                    MOC;

  modport master (
    input  InValid, InData, InLast, MOC,
    output InReady, MemEnable, MemRW, MemAddr, MemData, MemMode
  );

  modport slave (
    output InValid, InData, InLast, MOC,
    input  InReady, MemEnable, MemRW, MemAddr, MemData, MemMode
  );
endinterface

// File: rtl/sparc_ram_loader.sv
// Byte-stream to RAM loader. It packs incoming bytes big-endian into words
// of WORD_BYTES and writes each word with an enable/MOC handshake.
// Optional feature macro: LOADER_CHECKSUM_EN adds an 8-bit running checksum
// output of all accepted bytes.
module sparc_ram_loader #(
  parameter int ADDR_W     = 9,
  parameter int WORD_BYTES = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Start,
  sparc_ram_loader_if.master bus,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow,
  output logic [ADDR_W:0]   ByteCount
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        Checksum
`endif
);

  localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W:0]   BYTE_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]        MODE      = (WORD_BYTES == 1) ? 2'b00 :
                                            (WORD_BYTES == 2) ? 2'b01 : 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WRITE,
    WAIT_MOC,
    RELEASE,
    DONE
  } state_t;

  state_t            state;
  logic [LANE_W-1:0] laneIdx;
  logic              lastWord;
  logic              accept;
  logic              startSession;
  logic [ADDR_W:0]   nextAddr;

  // A byte transfers on handshake only in FILL; a new session starts only when idle or done.
  // nextAddr is computed one bit wider so that running past the top of RAM is visible.
  always_comb begin
    accept       = (state == FILL) && bus.InValid && bus.InReady;
    startSession = ((state == IDLE) || (state == DONE)) && Start;
    nextAddr     = {1'b0, bus.MemAddr} + (ADDR_W+1)'(WORD_BYTES);
  end

  // Session FSM with registered bus and status outputs.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state         <= IDLE;
      laneIdx       <= '0;
      lastWord      <= 1'b0;
      bus.InReady   <= 1'b0;
      bus.MemEnable <= 1'b0;
      bus.MemRW     <= 1'b1;
      bus.MemAddr   <= '0;
      bus.MemData   <= '0;
      bus.MemMode   <= 2'b00;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Overflow      <= 1'b0;
      ByteCount     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (startSession) begin
            state       <= FILL;
            laneIdx     <= '0;
            lastWord    <= 1'b0;
            bus.InReady <= 1'b1;
            bus.MemAddr <= ADDR_W'(BASE_ADDR);
            bus.MemData <= '0;
            bus.MemMode <= MODE;
            Busy        <= 1'b1;
            Done        <= 1'b0;
            Overflow    <= 1'b0;
            ByteCount   <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            for (int l = 0; l < WORD_BYTES; l++) begin
              if (laneIdx == LANE_W'(WORD_BYTES - 1 - l)) begin
                bus.MemData[8*l +: 8] <= bus.InData;
              end
            end
            if (ByteCount != BYTE_MAX) begin
              ByteCount <= ByteCount + (ADDR_W+1)'(1);
            end
            if ((laneIdx == LAST_LANE) || bus.InLast) begin
              state         <= WRITE;
              lastWord      <= bus.InLast;
              bus.InReady   <= 1'b0;
              bus.MemEnable <= 1'b1;
              bus.MemRW     <= 1'b0;
            end else begin
              laneIdx <= laneIdx + LANE_W'(1);
            end
          end
        end
        WRITE: begin
          state <= WAIT_MOC;
        end
        WAIT_MOC: begin
          if (bus.MOC) begin
            state         <= RELEASE;
            bus.MemEnable <= 1'b0;
            bus.MemRW     <= 1'b1;
          end
        end
        RELEASE: begin
          if (!bus.MOC) begin
            laneIdx <= '0;
            if (!nextAddr[ADDR_W]) begin
              bus.MemAddr <= nextAddr[ADDR_W-1:0];
            end
            if (lastWord) begin
              state <= DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else if (nextAddr[ADDR_W]) begin
              state    <= DONE;
              Busy     <= 1'b0;
              Done     <= 1'b1;
              Overflow <= 1'b1;
            end else begin
              state       <= FILL;
              bus.InReady <= 1'b1;
              bus.MemData <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Modulo-256 sum of every byte accepted in the current session.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      Checksum <= '0;
    end else if (startSession) begin
      Checksum <= '0;
    end else if (accept) begin
      Checksum <= Checksum + bus.InData;
    end
  end
`else
  // No checksum port or logic in the default build.
`endif

endmodule

// File: tb/tb_sparc_ram_loader.sv
// Self-checking bench for sparc_ram_loader. It drives randomized and directed
// byte sessions against a RAM responder with random MOC timing. Each session
// is compared against a word-level reference model.
module tb_sparc_ram_loader;

  localparam int ADDR_W     = 4;
  localparam int WORD_BYTES = 4;
  localparam int BASE_ADDR  = 0;
  localparam int CAPACITY   = (1 << ADDR_W) - BASE_ADDR;

  logic            Clk = 1'b0;
  logic            Clr;
  logic            Start;
  logic            Busy;
  logic            Done;
  logic            Overflow;
  logic [ADDR_W:0] ByteCount;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      Checksum;
`endif

  int assertCount = 0;
  int failCount   = 0;

  bit                ramAuto  = 1'b0;
  int                mocDelay = -1;
  int                mocHold  = -1;
  logic [ADDR_W-1:0] obsAddr[$];
  logic [31:0]       obsData[$];
  logic [7:0]        sessBytes[$];

  sparc_ram_loader_if #(.ADDR_W(ADDR_W), .WORD_BYTES(WORD_BYTES)) bus();

  sparc_ram_loader #(
    .ADDR_W(ADDR_W),
    .WORD_BYTES(WORD_BYTES),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .Clk(Clk),
    .Clr(Clr),
    .Start(Start),
    .bus(bus),
    .Busy(Busy),
    .Done(Done),
    .Overflow(Overflow),
    .ByteCount(ByteCount)
`ifdef LOADER_CHECKSUM_EN
    ,
    .Checksum(Checksum)
`endif
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  // Counts one comparison and reports it when the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // RAM responder: records each write request and raises MOC after a delay.
  // It then holds MOC past the enable drop, during which no new request may appear.
  initial begin : ramModel
    int d;
    int h;
    int n;
    logic [ADDR_W-1:0] a;
    logic [31:0] w;
    bus.MOC = 1'b0;
    forever begin
      @(negedge Clk);
      if (ramAuto && bus.MemEnable === 1'b1) begin
        a = bus.MemAddr;
        w = bus.MemData;
        obsAddr.push_back(a);
        obsData.push_back(w);
        checkOutput("memRwWrite", bus.MemRW, 0);
        checkOutput("memMode", bus.MemMode, 2'b10);
        checkOutput("inReadyDuringWrite", bus.InReady, 0);
        d = (mocDelay < 0) ? $urandom_range(0, 3) : mocDelay;
        h = (mocHold < 0) ? $urandom_range(0, 3) : mocHold;
        for (int i = 0; i < d; i++) begin
          @(negedge Clk);
          checkOutput("heldEnable", bus.MemEnable, 1);
          checkOutput("heldAddr", bus.MemAddr, a);
          checkOutput("heldData", bus.MemData, w);
        end
        bus.MOC = 1'b1;
        n = 0;
        while (bus.MemEnable === 1'b1 && n < 50) begin
          @(negedge Clk);
          n++;
        end
        checkOutput("enableDropTimeout", (n < 50), 1);
        for (int i = 0; i < h; i++) begin
          @(negedge Clk);
          checkOutput("noEnableWhileMoc", bus.MemEnable, 0);
        end
        bus.MOC = 1'b0;
      end
    end
  end

  // Drives one session from sessBytes with random idle gaps and a stray Start while busy.
  task automatic applyStimulus(input int startGlitchAt);
    int  idx;
    int  n;
    bit  rdy;
    bit  stop;
    obsAddr.delete();
    obsData.delete();
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    idx = 0;
    n   = 0;
    while (idx < sessBytes.size() && n < 600) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.InValid = 1'b0;
        bus.InData  = 8'($urandom);
        bus.InLast  = 1'($urandom);
      end else begin
        bus.InValid = 1'b1;
        bus.InData  = sessBytes[idx];
        bus.InLast  = (idx == sessBytes.size() - 1);
      end
      if (idx == startGlitchAt && Busy) Start = 1'b1;
      @(negedge Clk);
      rdy  = bus.InReady;
      stop = Done;
      @(posedge Clk); #1;
      Start = 1'b0;
      if (bus.InValid && rdy) idx++;
      if (stop) break;
      n++;
    end
    bus.InValid = 1'b0;
    bus.InLast  = 1'b0;
    checkOutput("streamTimeout", (n < 600), 1);
    n = 0;
    while (Done !== 1'b1 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("doneTimeout", (n < 300), 1);
    @(negedge Clk);
  endtask

  // Reference model: a session stores min(length, capacity) bytes as big-endian words
  // at consecutive word addresses, zero-padding the final word, and overflows when the
  // stream is longer than the RAM space above the base address.
  task automatic checkSession(input string name);
    int          accepted;
    int          words;
    int          sum;
    logic [31:0] ew;
    accepted = (sessBytes.size() > CAPACITY) ? CAPACITY : sessBytes.size();
    words    = (accepted + WORD_BYTES - 1) / WORD_BYTES;
    sum      = 0;
    for (int i = 0; i < accepted; i++) sum += sessBytes[i];
    checkOutput({name, ".done"}, Done, 1);
    checkOutput({name, ".busy"}, Busy, 0);
    checkOutput({name, ".overflow"}, Overflow, (sessBytes.size() > CAPACITY));
    checkOutput({name, ".byteCount"}, ByteCount, accepted);
    checkOutput({name, ".writeCount"}, obsAddr.size(), words);
`ifdef LOADER_CHECKSUM_EN
    checkOutput({name, ".checksum"}, Checksum, sum % 256);
`endif
    for (int wi = 0; wi < words && wi < obsAddr.size(); wi++) begin
      ew = '0;
      for (int b = 0; b < WORD_BYTES; b++) begin
        ew = ew << 8;
        if (WORD_BYTES * wi + b < accepted) ew[7:0] = sessBytes[WORD_BYTES * wi + b];
      end
      checkOutput($sformatf("%s.addr%0d", name, wi), obsAddr[wi], BASE_ADDR + WORD_BYTES * wi);
      checkOutput($sformatf("%s.data%0d", name, wi), obsData[wi], ew);
    end
  endtask

  // Pulls Clr low while a write waits for MOC; the enable must drop without a clock edge.
  task automatic clrMidWrite();
    int n;
    ramAuto = 1'b0;
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.InValid = 1'b1;
      bus.InData  = 8'(8'h11 * (i + 1));
      bus.InLast  = 1'b0;
      @(posedge Clk); #1;
    end
    bus.InValid = 1'b0;
    n = 0;
    while (bus.MemEnable !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    repeat (3) @(negedge Clk);
    checkOutput("clr.enableBefore", bus.MemEnable, 1);
    checkOutput("clr.busyBefore", Busy, 1);
    #2 Clr = 1'b0;
    #1;
    checkOutput("clr.enableAsync", bus.MemEnable, 0);
    checkOutput("clr.busyAsync", Busy, 0);
    checkOutput("clr.memRw", bus.MemRW, 1);
    checkOutput("clr.byteCount", ByteCount, 0);
    @(negedge Clk);
    Clr = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("clr.idleBusy", Busy, 0);
    checkOutput("clr.idleDone", Done, 0);
    checkOutput("clr.idleReady", bus.InReady, 0);
  endtask

  // Hard time limit so the run always ends.
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset checks, clear mid-write, directed sessions, random sessions.
  initial begin : mainSeq
    int len;
    Clr         = 1'b0;
    Start       = 1'b0;
    bus.InValid = 1'b0;
    bus.InData  = '0;
    bus.InLast  = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("reset.busy", Busy, 0);
    checkOutput("reset.done", Done, 0);
    checkOutput("reset.overflow", Overflow, 0);
    checkOutput("reset.byteCount", ByteCount, 0);
    checkOutput("reset.memEnable", bus.MemEnable, 0);
    checkOutput("reset.memRw", bus.MemRW, 1);
    checkOutput("reset.memMode", bus.MemMode, 0);
    checkOutput("reset.memAddr", bus.MemAddr, 0);
    checkOutput("reset.memData", bus.MemData, 0);
    checkOutput("reset.inReady", bus.InReady, 0);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("reset.checksum", Checksum, 0);
`endif
    Clr = 1'b1;
    repeat (2) @(negedge Clk);

    clrMidWrite();
    ramAuto = 1'b1;

    sessBytes.delete();
    for (int i = 1; i <= 8; i++) sessBytes.push_back(8'(i));
    mocDelay = 2; mocHold = 0;
    applyStimulus(3);
    checkSession("eightBytes");

    sessBytes.delete();
    sessBytes.push_back(8'hAA); sessBytes.push_back(8'hBB); sessBytes.push_back(8'hCC);
    applyStimulus(-1);
    checkSession("partialWord");

    sessBytes.delete();
    for (int i = 0; i < 6; i++) sessBytes.push_back(8'($urandom));
    mocDelay = 1; mocHold = 5;
    applyStimulus(-1);
    checkSession("mocHeld");

    sessBytes.delete();
    for (int i = 0; i < 20; i++) sessBytes.push_back(8'(8'h30 + i));
    mocDelay = -1; mocHold = -1;
    applyStimulus(5);
    checkSession("overflow20");

    sessBytes.delete();
    for (int i = 0; i < 16; i++) sessBytes.push_back(8'($urandom));
    applyStimulus(-1);
    checkSession("exactFill16");

    sessBytes.delete();
    for (int i = 0; i < 17; i++) sessBytes.push_back(8'($urandom));
    applyStimulus(-1);
    checkSession("overflow17");

    sessBytes.delete();
    sessBytes.push_back(8'hFF); sessBytes.push_back(8'h02);
    applyStimulus(-1);
    checkSession("checksumWrap");

    for (int s = 0; s < 25; s++) begin
      sessBytes.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) sessBytes.push_back(8'($urandom));
      applyStimulus($urandom_range(0, len));
      checkSession($sformatf("random%0d", s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sparc_ram_loader.md
SPARC_RAM_LOADER -- requirements
Module: sparc_ram_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 9, the byte-address width of the target RAM.
REQ-002 The module SHALL have parameter WORD_BYTES, default 4, the bytes packed per RAM write (legal values 1, 2, 4).
REQ-003 The module SHALL have parameter BASE_ADDR, default 0, the first byte address written after Start.
REQ-004 Clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Clr  in  1  asynchronous active-low reset.
REQ-006 Start  in  1  one-cycle pulse that begins a load session.
REQ-007 InValid / InReady  in / out  1 / 1  byte-stream handshake; a byte transfers when both are 1 at a rising edge.
REQ-008 InData  in  8  stream byte.
REQ-009 InLast  in  1  marks the final byte of the session; it is qualified by InValid.
REQ-010 MemEnable  out  1  RAM access request.
REQ-011 MemRW  out  1  RAM direction; 0 means write.
REQ-012 MemAddr  out  ADDR_W  byte address of the current word.
REQ-013 MemData  out  8*WORD_BYTES  packed word, first byte in the most significant lane (big-endian).
REQ-014 MemMode  out  2  access size: 00 byte, 01 halfword, 10 word, selected from WORD_BYTES.
REQ-015 MOC  in  1  RAM operation-complete flag.
REQ-016 Busy / Done / Overflow  out  1 each  session active, session finished, address space exhausted.
REQ-017 ByteCount  out  ADDR_W+1  bytes accepted in the current session.

Function
REQ-018 The module SHALL implement states IDLE, FILL, WRITE, WAIT_MOC, RELEASE and DONE.
REQ-019 In IDLE, Start SHALL load MemAddr with BASE_ADDR, clear ByteCount, Done and Overflow, and move to FILL.
REQ-020 In FILL, InReady SHALL be 1, and each accepted byte SHALL be placed in lane (WORD_BYTES-1-k), where k is the byte's index within the word.
REQ-021 When the WORD_BYTES-th byte is accepted, or InLast is accepted, the module SHALL move to WRITE on the next edge.
REQ-022 Unfilled lanes of a partial final word SHALL be 8'h00.
REQ-023 In WRITE and WAIT_MOC, MemEnable SHALL be 1, MemRW SHALL be 0, InReady SHALL be 0, and MemData and MemAddr SHALL be held stable.
REQ-024 WRITE SHALL last exactly one cycle and then move to WAIT_MOC.
REQ-025 The module SHALL stay in WAIT_MOC until MOC is sampled as 1, then move to RELEASE with MemEnable 0.
REQ-026 In RELEASE, the module SHALL wait for MOC to be sampled as 0 before leaving RELEASE, so that no new write starts while the RAM still holds MOC high.
REQ-027 On leaving RELEASE, MemAddr SHALL advance by WORD_BYTES, and the module SHALL move to DONE if the word held InLast, otherwise to FILL.
REQ-028 If MemAddr+WORD_BYTES would exceed 2^ADDR_W-1 and more bytes are expected, the module SHALL set Overflow, go to DONE, and never wrap the address.
REQ-029 In DONE, Done SHALL be 1 and Busy SHALL be 0, and the next Start SHALL begin a new session.
REQ-030 Busy SHALL be 1 in every state except IDLE and DONE.
REQ-031 Start SHALL be ignored while Busy is 1.
REQ-032 InValid SHALL be ignored outside FILL.
REQ-033 ByteCount SHALL saturate at 2^ADDR_W.

Reset
REQ-034 While Clr is 0, the module SHALL be in IDLE with every output 0, MemRW 1 (read, idle) and MemMode 00.
REQ-035 Asserting Clr mid-session SHALL abandon the session immediately, with MemEnable dropping asynchronously.
REQ-036 After Clr deasserts, the module SHALL wait in IDLE for a new Start.

Configuration
REQ-037 With LOADER_CHECKSUM_EN defined, the module SHALL add output Checksum[7:0], the modulo-256 sum of all accepted bytes, cleared on Start and reset and valid when Done is 1.
REQ-038 Without LOADER_CHECKSUM_EN, the module SHALL not have the Checksum port or its logic.

Verification
REQ-039 WORD_BYTES=4: stream 01,02,03,04,05,06,07,08 with InLast on 08, MOC returning 2 cycles after MemEnable -> writes 32'h01020304 @0 and 32'h05060708 @4, ByteCount=8, Done=1.
REQ-040 WORD_BYTES=4: stream AA,BB,CC with InLast on CC -> one write of 32'hAABBCC00 @0, MemMode=10.
REQ-041 MOC held high for 5 cycles after completion -> no second MemEnable until MOC returns to 0.
REQ-042 ADDR_W=4, WORD_BYTES=4: stream 20 bytes -> four writes @0,4,8,12, then Overflow=1, Done=1, and no write @16.
REQ-043 Clr pulsed low while in WAIT_MOC -> MemEnable=0 at once, Busy=0, and a fresh Start restarts at BASE_ADDR.
REQ-044 LOADER_CHECKSUM_EN defined: stream FF,02 with InLast on 02 -> Checksum=8'h01 when Done=1.
